// File: rtl/gtx_quad_reset_ctrl_if.sv
// Signals between the quad reset sequencer and one GTX quad wrapper.
// The master side is the sequencer; the slave side is the transceiver wrapper.
interface gtx_quad_reset_ctrl_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0] pll_lock;
  logic [LANES-1:0] tx_rst_done;
  logic [LANES-1:0] rx_rst_done;
  logic [LANES-1:0] rx_loss_sync;
  logic [LANES-1:0] pll_rx_reset;
  logic [LANES-1:0] gtx_tx_reset;
  logic [LANES-1:0] gtx_rx_reset;
  logic [LANES-1:0] tx_en_pma_phase_align;
  logic [LANES-1:0] tx_pma_set_phase;
  logic [LANES-1:0] rx_cdr_reset;

  modport master (
    input  pll_lock, tx_rst_done, rx_rst_done, rx_loss_sync,
    output pll_rx_reset, gtx_tx_reset, gtx_rx_reset,
           tx_en_pma_phase_align, tx_pma_set_phase, rx_cdr_reset
  );

  modport slave (
    output pll_lock, tx_rst_done, rx_rst_done, rx_loss_sync,
    input  pll_rx_reset, gtx_tx_reset, gtx_rx_reset,
           tx_en_pma_phase_align, tx_pma_set_phase, rx_cdr_reset
  );
endinterface

// File: rtl/gtx_quad_reset_ctrl.sv
// Bring-up sequencer for a 4-lane GTX quad: PLL/TX/RX resets, TX PMA phase
// alignment, retry/fault handling and per-lane RX CDR reset pulses in service.
module gtx_quad_reset_ctrl #(
  parameter int LANES        = 4,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int PHASE_EN_CYC = 512,
  parameter int SETPHASE_CYC = 8192,
  parameter int CDR_CYC      = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  gtx_quad_reset_ctrl_if.master gtx,
  output logic                  ready,
  output logic                  fault,
  output logic [2:0]            state
);

  localparam int HOLDOFF_CYC = 256;
  localparam int CDR_W       = $clog2(CDR_CYC + HOLDOFF_CYC + 1);

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT   = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] PE_LAST   = 16'(PHASE_EN_CYC - 1);
  localparam logic [15:0] SP_LAST   = 16'(SETPHASE_CYC - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  localparam logic [CDR_W-1:0] CDR_ONE   = CDR_W'(1);
  localparam logic [CDR_W-1:0] CDR_LAST  = CDR_W'(CDR_CYC);
  localparam logic [CDR_W-1:0] HOLD_LAST = CDR_W'(CDR_CYC + HOLDOFF_CYC);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_PHASE_EN  = 3'd4,
    ST_SET_PHASE = 3'd5,
    ST_READY     = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  logic [LANES-1:0] lock_m_q, lock_s_q, txd_m_q, txd_s_q;
  logic [LANES-1:0] rxd_m_q, rxd_s_q, los_m_q, los_s_q;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic        fail;
  logic        lock_all, done_all;

  logic pll_q, pll_d, txr_q, txr_d, rxr_q, rxr_d;
  logic align_q, align_d, setp_q, setp_d, ready_q, ready_d, fault_q, fault_d;

  logic [CDR_W-1:0] cdr_cnt_q [LANES];
  logic [CDR_W-1:0] cdr_cnt_d [LANES];
  logic [LANES-1:0] cdr_rst_q, cdr_rst_d;
  logic             cdr_en;

  // Status inputs come from the transceiver clock domains: two-flop synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m_q <= '0;
      lock_s_q <= '0;
      txd_m_q  <= '0;
      txd_s_q  <= '0;
      rxd_m_q  <= '0;
      rxd_s_q  <= '0;
      los_m_q  <= '0;
      los_s_q  <= '0;
    end else begin
      lock_m_q <= gtx.pll_lock;
      lock_s_q <= lock_m_q;
      txd_m_q  <= gtx.tx_rst_done;
      txd_s_q  <= txd_m_q;
      rxd_m_q  <= gtx.rx_rst_done;
      rxd_s_q  <= rxd_m_q;
      los_m_q  <= gtx.rx_loss_sync;
      los_s_q  <= los_m_q;
    end
  end

  assign lock_all = &lock_s_q;
  assign done_all = (&txd_s_q) & (&rxd_s_q);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      ST_RESET:     if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_all)              state_d = ST_RELEASE;
        else if (cnt_q == TIMEOUT) fail    = 1'b1;
      end
      ST_RELEASE: begin
        if (!lock_all) fail    = 1'b1;
        else           state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!lock_all)             fail    = 1'b1;
        else if (done_all)         state_d = ST_PHASE_EN;
        else if (cnt_q == TIMEOUT) fail    = 1'b1;
      end
      ST_PHASE_EN: begin
        if (!lock_all)             fail    = 1'b1;
        else if (cnt_q == PE_LAST) state_d = ST_SET_PHASE;
      end
      ST_SET_PHASE: begin
        if (!lock_all)             fail    = 1'b1;
        else if (cnt_q == SP_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (!lock_all) begin
          state_d = ST_RESET;
          retry_d = 3'd0;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET;
    endcase

    // Timeouts and lock loss before ready both consume one attempt.
    if (fail) begin
      if (retry_q == RETRY_MAX) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RESET;
        retry_d = retry_q + 3'd1;
      end
    end

    if (restart) begin
      state_d = ST_RESET;
      retry_d = 3'd0;
    end

    if (state_d != state_q || restart) cnt_d = '0;
    else if (cnt_q == 16'hFFFF)        cnt_d = cnt_q;
    else                               cnt_d = cnt_q + 16'd1;

    // Outputs decode the next state so they register in step with state_q.
    pll_d   = 1'b0;
    txr_d   = 1'b0;
    rxr_d   = 1'b0;
    align_d = 1'b0;
    setp_d  = 1'b0;
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_RESET: begin
        pll_d = 1'b1;
        txr_d = 1'b1;
        rxr_d = 1'b1;
      end
      ST_WAIT_LOCK: begin
        txr_d = 1'b1;
        rxr_d = 1'b1;
      end
      ST_PHASE_EN:  align_d = 1'b1;
      ST_SET_PHASE: begin
        align_d = 1'b1;
        setp_d  = 1'b1;
      end
      ST_READY: begin
        align_d = 1'b1;
        ready_d = 1'b1;
      end
      ST_FAULT: begin
        pll_d   = 1'b1;
        txr_d   = 1'b1;
        rxr_d   = 1'b1;
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-lane CDR counter: 0 idle, 1..CDR_CYC pulse, then HOLDOFF_CYC holdoff.
  always_comb begin
    cdr_en = (state_q == ST_READY) && (state_d == ST_READY);
    for (int i = 0; i < LANES; i++) begin
      cdr_cnt_d[i] = '0;
      if (cdr_en) begin
        if (cdr_cnt_q[i] == '0)
          cdr_cnt_d[i] = los_s_q[i] ? CDR_ONE : '0;
        else if (cdr_cnt_q[i] == CDR_LAST)
          cdr_cnt_d[i] = los_s_q[i] ? CDR_LAST + CDR_ONE : '0;
        else if (cdr_cnt_q[i] == HOLD_LAST)
          cdr_cnt_d[i] = los_s_q[i] ? CDR_ONE : '0;
        else
          cdr_cnt_d[i] = cdr_cnt_q[i] + CDR_ONE;
      end
      cdr_rst_d[i] = (cdr_cnt_d[i] != '0) && (cdr_cnt_d[i] <= CDR_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_q     <= 1'b1;
      txr_q     <= 1'b1;
      rxr_q     <= 1'b1;
      align_q   <= 1'b0;
      setp_q    <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      cdr_rst_q <= '0;
      for (int i = 0; i < LANES; i++) cdr_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_q     <= pll_d;
      txr_q     <= txr_d;
      rxr_q     <= rxr_d;
      align_q   <= align_d;
      setp_q    <= setp_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      cdr_rst_q <= cdr_rst_d;
      for (int i = 0; i < LANES; i++) cdr_cnt_q[i] <= cdr_cnt_d[i];
    end
  end

  assign gtx.pll_rx_reset          = {LANES{pll_q}};
  assign gtx.gtx_tx_reset          = {LANES{txr_q}};
  assign gtx.gtx_rx_reset          = {LANES{rxr_q}};
  assign gtx.tx_en_pma_phase_align = {LANES{align_q}};
  assign gtx.tx_pma_set_phase      = {LANES{setp_q}};
  assign gtx.rx_cdr_reset          = cdr_rst_q;
  assign ready                     = ready_q;
  assign fault                     = fault_q;
  assign state                     = state_q;

endmodule

// File: tb/tb_gtx_quad_reset_ctrl.sv
// Scoreboard bench for gtx_quad_reset_ctrl: expected state transitions and CDR
// pulses are queued by the stimulus and popped by independent monitors.
module tb_gtx_quad_reset_ctrl;

  localparam int LANES = 4;
  localparam int RST   = 8;
  localparam int LT    = 300;
  localparam int PE    = 32;
  localparam int SP    = 128;
  localparam int CDR   = 16;
  localparam int HOLD  = 256;

  localparam logic [2:0] S_RST = 3'd0, S_WL = 3'd1, S_REL = 3'd2, S_WD = 3'd3;
  localparam logic [2:0] S_PE  = 3'd4, S_SP = 3'd5, S_RDY = 3'd6, S_FLT = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       restart = 1'b0;
  logic       ready, fault;
  logic [2:0] state;

  gtx_quad_reset_ctrl_if #(.LANES(LANES)) gtx_if ();

  gtx_quad_reset_ctrl #(
    .LANES(LANES), .RST_CYCLES(RST), .LOCK_TIMEOUT(LT), .PHASE_EN_CYC(PE),
    .SETPHASE_CYC(SP), .CDR_CYC(CDR), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .gtx(gtx_if.master),
    .ready(ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] st; int dur; } trans_t;
  typedef struct { int lane; int width; int gap; } pulse_t;

  trans_t exp_q[$];
  pulse_t cdr_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     armed  = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int pack_act();
    return int'({gtx_if.pll_rx_reset, gtx_if.gtx_tx_reset, gtx_if.gtx_rx_reset,
                 gtx_if.tx_en_pma_phase_align, gtx_if.tx_pma_set_phase,
                 gtx_if.rx_cdr_reset, ready, fault});
  endfunction

  function automatic int exp_outs(input logic [2:0] st);
    logic p, t, r, a, s, rd, f;
    {p, t, r, a, s, rd, f} = 7'b0;
    case (st)
      S_RST: {p, t, r} = 3'b111;
      S_WL:  {t, r} = 2'b11;
      S_PE:  a = 1'b1;
      S_SP:  {a, s} = 2'b11;
      S_RDY: {a, rd} = 2'b11;
      S_FLT: {p, t, r, f} = 4'b1111;
      default: ;
    endcase
    return int'({{LANES{p}}, {LANES{t}}, {LANES{r}}, {LANES{a}}, {LANES{s}},
                 {LANES{1'b0}}, rd, f});
  endfunction

  task automatic push(input logic [2:0] st, input int dur);
    trans_t e;
    e.st  = st;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // Full bring-up from RESET with lock and done already present.
  task automatic push_fast_seq(input int reset_prev_dur);
    push(S_RST, reset_prev_dur);
    push(S_WL, RST);
    push(S_REL, 1);
    push(S_WD, 1);
    push(S_PE, 1);
    push(S_SP, PE);
    push(S_RDY, SP);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, input string name);
    int n;
    n = 0;
    while (state != st && n < max) begin
      tick(1);
      n++;
    end
    check(name, int'(state), int'(st));
  endtask

  // State-transition monitor: compares state, all outputs and prior-state length.
  initial begin
    logic [2:0] prev_st;
    int         run;
    trans_t     e;
    prev_st = S_RST;
    run     = 0;
    forever begin
      @(negedge clk);
      if (armed && state != prev_st) begin
        if (exp_q.size() == 0) begin
          check("unexpected_state_change", int'(state), -1);
        end else begin
          e = exp_q.pop_front();
          check("state_seq", int'(state), int'(e.st));
          check("state_outputs", pack_act(), exp_outs(e.st));
          if (e.dur >= 0) check("prev_state_cycles", run, e.dur);
        end
      end
      if (!rst_n)                run = 0;
      else if (state != prev_st) run = 1;
      else                       run++;
      prev_st = state;
    end
  end

  // CDR pulse monitor: reports each completed pulse per lane.
  initial begin
    logic [LANES-1:0] prev_c;
    int               ccyc;
    int               rise [LANES];
    int               last_rise [LANES];
    pulse_t           p;
    prev_c = '0;
    ccyc   = 0;
    for (int i = 0; i < LANES; i++) begin
      rise[i]      = 0;
      last_rise[i] = -1;
    end
    forever begin
      @(negedge clk);
      ccyc++;
      for (int i = 0; i < LANES; i++) begin
        if (gtx_if.rx_cdr_reset[i] && !prev_c[i]) rise[i] = ccyc;
        if (!gtx_if.rx_cdr_reset[i] && prev_c[i]) begin
          if (cdr_q.size() == 0) begin
            check("unexpected_cdr_pulse_lane", i, -1);
          end else begin
            p = cdr_q.pop_front();
            check("cdr_lane", i, p.lane);
            check("cdr_width", ccyc - rise[i], p.width);
            if (p.gap >= 0) check("cdr_rise_spacing", rise[i] - last_rise[i], p.gap);
          end
          last_rise[i] = rise[i];
        end
      end
      prev_c = gtx_if.rx_cdr_reset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int     k;
    pulse_t p;
    gtx_if.pll_lock     = '0;
    gtx_if.tx_rst_done  = '0;
    gtx_if.rx_rst_done  = '0;
    gtx_if.rx_loss_sync = '0;

    #3 rst_n = 1'b0;
    tick(3);
    check("reset_state", int'(state), int'(S_RST));
    check("reset_outputs", pack_act(), exp_outs(S_RST));

    // T1: lock 100 cycles after release, done 20 cycles later.
    push(S_WL, RST);
    push(S_REL, -1);
    push(S_WD, 1);
    push(S_PE, -1);
    push(S_SP, PE);
    push(S_RDY, SP);
    armed = 1'b1;
    rst_n = 1'b1;
    tick(100);
    gtx_if.pll_lock = '1;
    tick(20);
    gtx_if.tx_rst_done = '1;
    gtx_if.rx_rst_done = '1;
    wait_state(S_RDY, 2000, "t1_ready");
    check("t1_fault_low", int'(fault), 0);
    tick(5);

    // T4: loss of sync on lane 1 for 1000 cycles.
    for (int i = 0; i < 4; i++) begin
      p.lane  = 1;
      p.width = CDR;
      p.gap   = (i == 0) ? -1 : CDR + HOLD;
      cdr_q.push_back(p);
    end
    gtx_if.rx_loss_sync = 4'b0010;
    tick(1000);
    gtx_if.rx_loss_sync = '0;
    tick(400);
    check("t4_pulses_outstanding", cdr_q.size(), 0);
    check("t4_state_ready", int'(state), int'(S_RDY));

    // T3: one-cycle drop of pll_lock[2] from ready.
    push_fast_seq(-1);
    gtx_if.pll_lock = 4'b1011;
    k = 0;
    while (ready && k < 8) begin
      tick(1);
      k++;
      gtx_if.pll_lock = '1;
    end
    check("t3_ready_drop_within_3", int'(k <= 3 && !ready), 1);
    wait_state(S_RDY, 1000, "t3_ready_again");
    tick(5);

    // T5: restart from ready, then again in the middle of SET_PHASE.
    push(S_RST, -1);
    push(S_WL, RST);
    push(S_REL, 1);
    push(S_WD, 1);
    push(S_PE, 1);
    push(S_SP, PE);
    pulse_restart();
    wait_state(S_SP, 500, "t5_in_set_phase");
    tick(10);
    push_fast_seq(-1);
    pulse_restart();
    check("t5_set_phase_dropped", int'(gtx_if.tx_pma_set_phase), 0);
    check("t5_state_reset", int'(state), int'(S_RST));
    wait_state(S_RDY, 1000, "t5_ready_again");
    tick(5);

    // T6: asynchronous reset while waiting for reset-done.
    gtx_if.tx_rst_done = '0;
    tick(2);
    push(S_RST, -1);
    push(S_WL, RST);
    push(S_REL, 1);
    push(S_WD, 1);
    pulse_restart();
    wait_state(S_WD, 500, "t6_in_wait_done");
    tick(20);
    @(negedge clk);
    #2;
    push(S_RST, -1);
    rst_n = 1'b0;
    #1;
    check("t6_async_state", int'(state), int'(S_RST));
    check("t6_async_outputs", pack_act(), exp_outs(S_RST));
    gtx_if.tx_rst_done = '1;
    tick(3);
    push(S_WL, RST);
    push(S_REL, 1);
    push(S_WD, 1);
    push(S_PE, 1);
    push(S_SP, PE);
    push(S_RDY, SP);
    rst_n = 1'b1;
    wait_state(S_RDY, 1000, "t6_ready_again");
    tick(5);

    // One timeout leaves the retry counter at 1 before reaching ready.
    push(S_RST, -1);
    push(S_WL, RST);
    push(S_RST, LT + 1);
    push(S_WL, RST);
    push(S_REL, -1);
    push(S_WD, 1);
    push(S_PE, 1);
    push(S_SP, PE);
    push(S_RDY, SP);
    gtx_if.pll_lock = '0;
    pulse_restart();
    wait_state(S_WL, 100, "retry_first_wait_lock");
    wait_state(S_RST, 1000, "retry_timeout_to_reset");
    wait_state(S_WL, 100, "retry_second_wait_lock");
    tick(20);
    gtx_if.pll_lock = '1;
    wait_state(S_RDY, 1000, "retry_ready");
    tick(5);

    // T2: lock lost from ready (retry cleared), never returns: four timeouts then fault.
    push(S_RST, -1);
    for (int i = 0; i < 3; i++) begin
      push(S_WL, RST);
      push(S_RST, LT + 1);
    end
    push(S_WL, RST);
    push(S_FLT, LT + 1);
    gtx_if.pll_lock = '0;
    wait_state(S_FLT, 3000, "t2_fault_state");
    tick(10);
    check("t2_fault_sticky", int'(fault), 1);
    push(S_RST, -1);
    push(S_WL, RST);
    pulse_restart();
    check("t2_fault_cleared", int'(fault), 0);
    check("t2_state_after_restart", int'(state), int'(S_RST));
    wait_state(S_WL, 100, "t2_wait_lock_after_restart");
    tick(5);

    check("transitions_outstanding", exp_q.size(), 0);
    check("cdr_pulses_outstanding", cdr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
